// File: rtl/ntt_pkg.sv
// Shared types and defaults for the NTT vector loader: FSM state, default
// geometry/modulus and the bit-reversal helper.
package ntt_pkg;

  localparam int unsigned NTT_W = 32;
  localparam int unsigned NTT_N = 8;
  localparam int unsigned NTT_Q = 134221489;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } ntt_state_e;

  // Reverses the low `bits` bits of v; higher bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned bits);
    logic [31:0] r;
    r = '0;
    for (int unsigned b = 0; b < bits; b++) begin
      r[b] = v[bits-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bitrev_idx.sv
// Combinational bit-reversed slot index for the NTT vector loader
// (used only when NTT_LOADER_BITREV_EN is defined).
module ntt_bitrev_idx
  import ntt_pkg::*;
#(
  parameter int unsigned IW = 3
) (
  input  logic [IW-1:0] idx_i,
  output logic [IW-1:0] slot_o
);

  assign slot_o = IW'(bitrev(32'(idx_i), IW));

endmodule

// File: rtl/ntt_vector_loader.sv
// Serial-to-parallel coefficient loader feeding an NTT core, with sticky
// range/frame error flags. Optional macro NTT_LOADER_BITREV_EN stores
// coefficients in bit-reversed slot order.
module ntt_vector_loader
  import ntt_pkg::*;
#(
  parameter int unsigned W         = NTT_W,
  parameter int unsigned N         = NTT_N,
  parameter int unsigned Modulus_Q = NTT_Q
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           coef_valid,
  output logic           coef_ready,
  input  logic [W-1:0]   coef_data,
  input  logic           coef_last,
  input  logic           mode_in,
  output logic [N*W-1:0] vec_out,
  output logic           vec_valid,
  output logic           vec_mode,
  output logic           range_err,
  output logic           frame_err,
  input  logic           err_clr
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = (W > 32) ? W : 32;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  ntt_state_e            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         slot;
  logic                  mode_q, mode_d;
  logic                  rdy_q;
  logic [N-1:0][W-1:0]   shadow_q, shadow_d;
  logic [N*W-1:0]        vec_out_q, vec_out_d;
  logic                  vec_mode_q, vec_mode_d;
  logic                  range_q, range_d;
  logic                  frame_q, frame_d;
  logic                  accept;
  logic                  over_q;

`ifdef NTT_LOADER_BITREV_EN
  ntt_bitrev_idx #(.IW(IW)) u_bitrev (
    .idx_i  (idx_q),
    .slot_o (slot)
  );
`else
  assign slot = idx_q;
`endif

  // rdy_q keeps coef_ready low until the first clock edge after reset release.
  assign coef_ready = rdy_q && (state_q == FILL);
  assign vec_valid  = (state_q == EMIT);
  assign vec_out    = vec_out_q;
  assign vec_mode   = vec_mode_q;
  assign range_err  = range_q;
  assign frame_err  = frame_q;
  assign accept     = coef_valid && coef_ready;
  assign over_q     = CW'(coef_data) >= CW'(Modulus_Q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    shadow_d   = shadow_q;
    vec_out_d  = vec_out_q;
    vec_mode_d = vec_mode_q;
    range_d    = range_q && !err_clr;
    frame_d    = frame_q && !err_clr;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          shadow_d[slot] = coef_data;
          if (idx_q == '0) mode_d = mode_in;
          if (over_q) range_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            state_d    = EMIT;
            vec_out_d  = shadow_d;
            vec_mode_d = mode_d;
            if (!coef_last) frame_d = 1'b1;
          end else if (coef_last) begin
            // Short frame: drop it and restart at slot 0.
            idx_d   = '0;
            frame_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EMIT: state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      idx_q      <= '0;
      mode_q     <= 1'b0;
      rdy_q      <= 1'b0;
      shadow_q   <= '0;
      vec_out_q  <= '0;
      vec_mode_q <= 1'b0;
      range_q    <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      rdy_q      <= 1'b1;
      shadow_q   <= shadow_d;
      vec_out_q  <= vec_out_d;
      vec_mode_q <= vec_mode_d;
      range_q    <= range_d;
      frame_q    <= frame_d;
    end
  end

endmodule

// File: tb/tb_ntt_vector_loader.sv
// Self-checking bench for ntt_vector_loader; the reference model builds each
// expected vector directly from the words sent (bit-reversed slots when
// NTT_LOADER_BITREV_EN is defined).
module tb_ntt_vector_loader;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 8;
  localparam int unsigned LG = 3;
  localparam logic [31:0] Q  = 32'd134221489;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           coef_valid = 1'b0;
  logic           coef_ready;
  logic [W-1:0]   coef_data = '0;
  logic           coef_last = 1'b0;
  logic           mode_in = 1'b0;
  logic [N*W-1:0] vec_out;
  logic           vec_valid;
  logic           vec_mode;
  logic           range_err;
  logic           frame_err;
  logic           err_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  int unsigned    cyc = 0;
  int unsigned    vv_cyc[$];
  logic [N*W-1:0] vv_vec[$];
  logic           vv_mode[$];

  logic [W-1:0]   words[N];
  logic [N*W-1:0] last_vec = '0;

  ntt_vector_loader #(.W(W), .N(N), .Modulus_Q(134221489)) dut (
    .clk        (clk),
    .reset      (reset),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .coef_last  (coef_last),
    .mode_in    (mode_in),
    .vec_out    (vec_out),
    .vec_valid  (vec_valid),
    .vec_mode   (vec_mode),
    .range_err  (range_err),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (vec_valid === 1'b1) begin
      vv_cyc.push_back(cyc);
      vv_vec.push_back(vec_out);
      vv_mode.push_back(vec_mode);
    end
  end

  function automatic int unsigned slot_of(input int unsigned i);
`ifdef NTT_LOADER_BITREV_EN
    int unsigned r = 0;
    int unsigned x = i;
    for (int unsigned b = 0; b < LG; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
`else
    return i;
`endif
  endfunction

  function automatic logic [N*W-1:0] model_vec();
    logic [N*W-1:0] v = '0;
    for (int unsigned i = 0; i < N; i++) v[slot_of(i)*W +: W] = words[i];
    return v;
  endfunction

  function automatic logic model_range();
    logic r = 1'b0;
    for (int unsigned i = 0; i < N; i++) if (words[i] >= Q) r = 1'b1;
    return r;
  endfunction

  task automatic clear_q();
    vv_cyc.delete();
    vv_vec.delete();
    vv_mode.delete();
  endtask

  task automatic idle(input int unsigned n);
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic put(input logic [W-1:0] d, input logic last, input logic m, output int unsigned waits);
    waits = 0;
    coef_valid = 1'b1;
    coef_data  = d;
    coef_last  = last;
    mode_in    = m;
    while (coef_ready !== 1'b1 && waits < 16) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 16) begin
      total++; bad++;
      $display("FAIL put_timeout coef_ready=%b required=1", coef_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_words(input int unsigned cnt, input logic m, input logic last_at_end,
                            input bit gaps, output int unsigned wt);
    int unsigned w;
    wt = 0;
    for (int unsigned i = 0; i < cnt; i++) begin
      if (gaps && ($urandom % 3 == 0)) idle(1);
      put(words[i], last_at_end && (i == cnt - 1), (i == 0) ? m : 1'($urandom), w);
      wt += w;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    total++; if (coef_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", coef_ready); end
    total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", vec_valid); end
    total++; if (vec_out !== '0) begin bad++; $display("FAIL rst_vec got=%h want=0", vec_out); end
    total++; if (vec_mode !== 1'b0) begin bad++; $display("FAIL rst_mode got=%b want=0", vec_mode); end
    total++; if ({range_err, frame_err} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b want=00", {range_err, frame_err}); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (coef_ready !== 1'b0) begin bad++; $display("FAIL rel_ready_early got=%b want=0", coef_ready); end
    @(negedge clk);
    total++; if (coef_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b want=1", coef_ready); end
  endtask

  task automatic test_basic();
    int unsigned wt;
    for (int unsigned i = 0; i < N; i++) words[i] = (i < 5) ? W'(123412341 + i) : '0;
    send_words(N, 1'b0, 1'b1, 1'b0, wt);
    last_vec = model_vec();
    total++; if (vec_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", vec_valid); end
    total++; if (coef_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_emit got=%b want=0", coef_ready); end
    total++; if (vec_out !== last_vec) begin bad++; $display("FAIL basic_vec got=%h want=%h", vec_out, last_vec); end
    total++; if (vec_mode !== 1'b0) begin bad++; $display("FAIL basic_mode got=%b want=0", vec_mode); end
    total++; if ({range_err, frame_err} !== 2'b00) begin bad++; $display("FAIL basic_err got=%b want=00", {range_err, frame_err}); end
    idle(1);
    total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b want=0", vec_valid); end
    total++; if (coef_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_fill got=%b want=1", coef_ready); end
    total++; if (vec_out !== last_vec) begin bad++; $display("FAIL basic_hold got=%h want=%h", vec_out, last_vec); end
  endtask

  task automatic test_back_to_back();
    int unsigned wa, wb;
    logic [N*W-1:0] exp_a, exp_b;
    clear_q();
    for (int unsigned i = 0; i < N; i++) words[i] = W'($urandom % Q);
    exp_a = model_vec();
    send_words(N, 1'b0, 1'b1, 1'b0, wa);
    for (int unsigned i = 0; i < N; i++) words[i] = W'($urandom % Q);
    exp_b = model_vec();
    send_words(N, 1'b1, 1'b1, 1'b0, wb);
    idle(3);
    last_vec = exp_b;
    total++; if (wa !== 0) begin bad++; $display("FAIL b2b_stall_a got=%0d want=0", wa); end
    total++; if (wb !== 1) begin bad++; $display("FAIL b2b_stall_b got=%0d want=1", wb); end
    total++;
    if (vv_cyc.size() != 2) begin
      bad++; $display("FAIL b2b_count got=%0d want=2", vv_cyc.size());
    end else begin
      if (vv_cyc[1] - vv_cyc[0] !== 9) begin bad++; $display("FAIL b2b_spacing got=%0d want=9", vv_cyc[1] - vv_cyc[0]); end
      total++; if (vv_vec[0] !== exp_a) begin bad++; $display("FAIL b2b_vec_a got=%h want=%h", vv_vec[0], exp_a); end
      total++; if (vv_vec[1] !== exp_b) begin bad++; $display("FAIL b2b_vec_b got=%h want=%h", vv_vec[1], exp_b); end
      total++; if ({vv_mode[0], vv_mode[1]} !== 2'b01) begin bad++; $display("FAIL b2b_mode got=%b want=01", {vv_mode[0], vv_mode[1]}); end
    end
  endtask

  task automatic test_frame_err();
    int unsigned wt;
    logic [N*W-1:0] exp_v;
    clear_q();
    for (int unsigned i = 0; i < N; i++) words[i] = W'($urandom % Q);
    send_words(5, 1'b1, 1'b1, 1'b0, wt);
    idle(3);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_ferr got=%b want=1", frame_err); end
    total++; if (vv_cyc.size() != 0) begin bad++; $display("FAIL short_emit got=%0d want=0", vv_cyc.size()); end
    total++; if (vec_out !== last_vec) begin bad++; $display("FAIL short_hold got=%h want=%h", vec_out, last_vec); end
    for (int unsigned i = 0; i < N; i++) words[i] = W'($urandom % Q);
    exp_v = model_vec();
    send_words(N, 1'b0, 1'b1, 1'b0, wt);
    idle(2);
    total++; if (vv_cyc.size() != 1 || vv_vec[0] !== exp_v) begin bad++; $display("FAIL after_short_vec got=%h want=%h", vec_out, exp_v); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_sticky got=%b want=1", frame_err); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clr got=%b want=0", frame_err); end
    for (int unsigned i = 0; i < N; i++) words[i] = W'($urandom % Q);
    exp_v = model_vec();
    send_words(N, 1'b0, 1'b0, 1'b0, wt);
    idle(2);
    last_vec = exp_v;
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL nolast_ferr got=%b want=1", frame_err); end
    total++; if (vv_cyc.size() != 2 || vv_vec[1] !== exp_v) begin bad++; $display("FAIL nolast_vec got=%h want=%h", vec_out, exp_v); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clr2 got=%b want=0", frame_err); end
  endtask

  task automatic test_range_err();
    int unsigned wt;
    logic [N*W-1:0] exp_v;
    clear_q();
    for (int unsigned i = 0; i < N; i++) words[i] = W'($urandom % Q);
    words[1] = Q - 1;
    words[2] = Q;
    exp_v = model_vec();
    for (int unsigned i = 0; i < N; i++) begin
      put(words[i], i == N - 1, 1'b0, wt);
      if (i == 1) begin
        total++; if (range_err !== 1'b0) begin bad++; $display("FAIL rng_below got=%b want=0", range_err); end
      end
      if (i == 2) begin
        total++; if (range_err !== 1'b1) begin bad++; $display("FAIL rng_at_q got=%b want=1", range_err); end
      end
    end
    idle(2);
    total++; if (vec_out !== exp_v) begin bad++; $display("FAIL rng_vec got=%h want=%h", vec_out, exp_v); end
    total++; if (vec_out[slot_of(2)*W +: W] !== Q) begin bad++; $display("FAIL rng_stored got=%0d want=%0d", vec_out[slot_of(2)*W +: W], Q); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL rng_clr got=%b want=0", range_err); end
    for (int unsigned i = 0; i < N; i++) words[i] = W'($urandom % Q);
    words[0] = Q + 5;
    exp_v = model_vec();
    err_clr = 1'b1;
    put(words[0], 1'b0, 1'b1, wt);
    err_clr = 1'b0;
    total++; if (range_err !== 1'b1) begin bad++; $display("FAIL rng_err_wins got=%b want=1", range_err); end
    for (int unsigned i = 1; i < N; i++) put(words[i], i == N - 1, 1'b0, wt);
    idle(2);
    last_vec = exp_v;
    total++; if (vec_out !== exp_v || vec_mode !== 1'b1) begin bad++; $display("FAIL rng_frame2 got=%h/%b want=%h/1", vec_out, vec_mode, exp_v); end
  endtask

  task automatic test_reset_midframe();
    int unsigned wt;
    logic [N*W-1:0] exp_v;
    for (int unsigned i = 0; i < N; i++) words[i] = W'($urandom % Q);
    words[1] = Q;
    send_words(4, 1'b1, 1'b0, 1'b0, wt);
    #2 reset = 1'b0;
    #1;
    total++; if (coef_ready !== 1'b0 || vec_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_hs got=%b%b want=00", coef_ready, vec_valid); end
    total++; if (vec_out !== '0 || vec_mode !== 1'b0) begin bad++; $display("FAIL mid_rst_vec got=%h/%b want=0/0", vec_out, vec_mode); end
    total++; if ({range_err, frame_err} !== 2'b00) begin bad++; $display("FAIL mid_rst_err got=%b want=00", {range_err, frame_err}); end
    coef_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_q();
    @(negedge clk);
    for (int unsigned i = 0; i < N; i++) words[i] = W'(i);
    exp_v = model_vec();
    send_words(N, 1'b0, 1'b1, 1'b0, wt);
    idle(2);
    last_vec = exp_v;
    total++; if (vv_cyc.size() != 1) begin bad++; $display("FAIL mid_emit_count got=%0d want=1", vv_cyc.size()); end
    total++; if (vec_out !== exp_v || vec_mode !== 1'b0) begin bad++; $display("FAIL mid_fresh_vec got=%h want=%h", vec_out, exp_v); end
  endtask

  task automatic test_random();
    int unsigned wt;
    logic m;
    logic [N*W-1:0] exp_v;
    for (int unsigned f = 0; f < 6; f++) begin
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      clear_q();
      for (int unsigned i = 0; i < N; i++)
        words[i] = ($urandom % 4 == 0) ? W'(Q - 1 + $urandom % 3) : W'($urandom % Q);
      m = 1'($urandom);
      exp_v = model_vec();
      send_words(N, m, 1'b1, 1'b1, wt);
      idle(2);
      total++;
      if (vv_cyc.size() != 1 || vv_vec[0] !== exp_v || vv_mode[0] !== m) begin
        bad++; $display("FAIL rand_vec f=%0d got=%h want=%h mode_want=%b", f, vec_out, exp_v, m);
      end
      total++; if (range_err !== model_range()) begin bad++; $display("FAIL rand_range f=%0d got=%b want=%b", f, range_err, model_range()); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rand_ferr f=%0d got=%b want=0", f, frame_err); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_range_err();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_vector_loader.md
NTT_VECTOR_LOADER -- requirements
Module: ntt_vector_loader

Interface
REQ-001 SHALL have parameter W, default 32: coefficient width in bits.
REQ-002 SHALL have parameter N, default 8: coefficients per vector; a power of two, at least 2.
REQ-003 SHALL have parameter Modulus_Q, default 134221489: range-check bound.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port coef_valid, input, 1 bit: a serial coefficient is offered.
REQ-007 SHALL have port coef_ready, output, 1 bit: the loader accepts a coefficient this cycle.
REQ-008 SHALL have port coef_data, input, W bits: serial coefficient value.
REQ-009 SHALL have port coef_last, input, 1 bit: the offered coefficient is the final one of its frame.
REQ-010 SHALL have port mode_in, input, 1 bit: NTT (0) or iNTT (1) select; sampled with the first coefficient of a frame.
REQ-011 SHALL have port vec_out, output, N x W bits: parallel vector for the NTT Data_in.
REQ-012 SHALL have port vec_valid, output, 1 bit: one-cycle pulse for the NTT data_valid_in.
REQ-013 SHALL have port vec_mode, output, 1 bit: mode for the NTT iNTT_mode.
REQ-014 SHALL have ports range_err and frame_err, outputs, 1 bit each: sticky error flags.
REQ-015 SHALL have port err_clr, input, 1 bit: clears both sticky error flags.

Function
REQ-016 SHALL implement an FSM with two states, FILL and EMIT; FILL is the reset state.
REQ-017 In FILL, coef_ready SHALL be 1; a coefficient is accepted on a rising edge when coef_valid and coef_ready are both 1.
REQ-018 An accepted coefficient SHALL be written into slot idx, where idx is a log2(N)-bit counter, and idx SHALL then increment.
REQ-019 mode_in SHALL be latched into the frame-mode register only when idx is 0 at acceptance.
REQ-020 Acceptance at idx = N-1 SHALL wrap idx to 0 and move the FSM to EMIT, whatever the value of coef_last.
REQ-021 Acceptance at idx = N-1 with coef_last = 0 SHALL set frame_err.
REQ-022 Acceptance with coef_last = 1 and idx < N-1 SHALL set frame_err, reset idx to 0 and stay in FILL; the partial frame is discarded and nothing is emitted.
REQ-023 In EMIT, vec_valid and coef_ready SHALL be 1 and 0 respectively, for exactly one cycle; the FSM SHALL then return to FILL.
REQ-024 Latency: last coefficient accepted at edge k gives vec_valid high during the cycle following edge k; sustained throughput is one vector per N+1 cycles.
REQ-025 vec_out and vec_mode SHALL be registered and held stable from EMIT until the next EMIT.
REQ-026 In FILL, writes SHALL go to a shadow buffer that is copied to vec_out on entry to EMIT, so vec_out never shows a partial frame.
REQ-027 An accepted coefficient with coef_data >= Modulus_Q SHALL set range_err; the value SHALL be stored unmodified.
REQ-028 If err_clr and a new error-setting event occur in the same cycle, the error SHALL win (flag = 1).

Reset
REQ-029 Assertion of reset (low) SHALL immediately force the following: FSM to FILL, idx = 0, vec_valid = 0, vec_mode = 0, vec_out all 0, shadow buffer all 0, range_err = 0, frame_err = 0.
REQ-030 coef_ready SHALL be 0 while reset is asserted and 1 from the first edge after release.
REQ-031 Reset mid-frame SHALL discard the partial frame without emitting it.

Configuration
REQ-032 When macro NTT_LOADER_BITREV_EN is defined, coefficient idx SHALL be stored in slot bitrev(idx) over log2(N) bits; for N = 8, 1->4, 3->6 and 6->3.
REQ-033 When NTT_LOADER_BITREV_EN is undefined, coefficient idx SHALL be stored in slot idx.

Structure
REQ-034 Shared package ntt_pkg SHALL hold the FSM state enum, the default W/N/Q constants and a bitrev function.
REQ-035 Sub-module ntt_bitrev_idx SHALL be the natural one: a combinational index permutation, instantiated only under NTT_LOADER_BITREV_EN.

Verification
REQ-036 Stream 123412341..123412345, 0, 0, 0 with coef_last on the 8th word, mode_in = 0 -> vec_valid pulses for one cycle, the cycle after the 8th accept; vec_out equals the input order; vec_mode = 0; no errors.
REQ-037 Two back-to-back frames with coef_valid held high -> coef_ready drops for exactly one cycle between frames; vec_valid pulses 9 cycles apart.
REQ-038 coef_last asserted on the 5th word -> frame_err = 1, no vec_valid; the next full frame emits normally with frame_err still 1 until err_clr.
REQ-039 Word 134221489 (= Q) at idx 2 -> range_err = 1; vec_out[2] = 134221489; err_clr asserted alone clears it next cycle.
REQ-040 reset pulsed low after 4 accepted words -> all outputs 0; a fresh 8-word frame then emits correctly; with NTT_LOADER_BITREV_EN, input 0..7 gives vec_out = 0,4,2,6,1,5,3,7.
